// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner and its settle timer.
// The scan walks every input vector of a 4-in/4-out block under test.
package truth_table_scanner_pkg;

    localparam int N_VECTORS = 16;
    localparam int VEC_W     = 4;
    localparam int OUT_W     = 4;
    localparam int CNT_W     = 8;
    localparam int MCNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic is_last_vec(input logic [VEC_W-1:0] idx);
        return idx == VEC_W'(N_VECTORS - 1);
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter.
// expire_o flags the final count (1), so the owner can act on the same edge the hold time ends.
module settle_timer
    import truth_table_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expire_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Sequencer that steps abcd through all 16 vectors.
// Each vector is held SETTLE_CYCLES cycles, then the DUT outputs are captured and compared against the reference.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [VEC_W-1:0]  abcd,
    input  logic [OUT_W-1:0]  f_dut,
    input  logic [OUT_W-1:0]  f_ref,
    output logic              busy,
    output logic              done,
    output logic [MCNT_W-1:0] mismatch_cnt,
    output logic              fail_seen,
    output logic [VEC_W-1:0]  first_fail,
    input  logic [VEC_W-1:0]  rd_addr,
    output logic [OUT_W-1:0]  rd_data
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_t              state_q;
    logic [VEC_W-1:0]    idx_q;
    logic [VEC_W-1:0]    idx_d;
    logic [VEC_W-1:0]    abcd_q;
    logic                busy_q;
    logic                done_q;
    logic [MCNT_W-1:0]   mcnt_q;
    logic                fail_q;
    logic [VEC_W-1:0]    first_q;
    logic [OUT_W-1:0]    table_q [N_VECTORS];

    logic start_ok;
    logic capture;
    logic last_vec;
    logic vec_bad;
    logic timer_load;
    logic timer_en;
    logic timer_expire;

    assign idx_d      = idx_q + VEC_W'(1);
    assign start_ok   = (state_q == IDLE) && start && !abort;
    assign capture    = (state_q == SAMPLE) && !abort;
    assign last_vec   = is_last_vec(idx_q);
    assign vec_bad    = (f_dut != f_ref);
    assign timer_load = start_ok || (capture && !last_vec);
    assign timer_en   = (state_q == SETTLE) && !abort;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LOAD),
        .en_i       (timer_en),
        .expire_o   (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mcnt_q  <= '0;
            fail_q  <= 1'b0;
            first_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                // Partial results stay visible; only the sequencing is dropped.
                state_q <= IDLE;
                abcd_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        abcd_q <= '0;
                        if (start_ok) begin
                            idx_q   <= '0;
                            mcnt_q  <= '0;
                            fail_q  <= 1'b0;
                            first_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (timer_expire) begin
                            state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        if (vec_bad) begin
                            mcnt_q <= mcnt_q + MCNT_W'(1);
                            if (!fail_q) begin
                                first_q <= idx_q;
                                fail_q  <= 1'b1;
                            end
                        end
                        if (last_vec) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_d;
                            abcd_q  <= idx_d;
                            state_q <= SETTLE;
                        end
                    end
                    DONE: begin
                        abcd_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        abcd_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < N_VECTORS; gi++) begin : g_table
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                table_q[gi] <= '0;
            end else if (capture && (idx_q == VEC_W'(gi))) begin
                table_q[gi] <= f_dut;
            end
        end
    end

    assign rd_data      = table_q[rd_addr];
    assign abcd         = abcd_q;
    assign busy         = busy_q;
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign done         = done_q && !abort;
    assign mismatch_cnt = mcnt_q;
    assign fail_seen    = fail_q;
    assign first_fail   = first_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner with SETTLE_CYCLES=4.
// The block under test is modelled as f=~abcd, with selectable reference faults.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  abcd;
    logic [3:0]  f_dut;
    logic [3:0]  f_ref;
    logic        busy;
    logic        done;
    logic [4:0]  mismatch_cnt;
    logic        fail_seen;
    logic [3:0]  first_fail;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_data;
    logic [15:0] fault_mask;

    int n_checks = 0;
    int n_errors = 0;
    int dc, dn, bf, bh;

    always #5 clk = ~clk;

    always_comb begin
        f_dut = ~abcd;
        f_ref = f_dut ^ (fault_mask[abcd] ? 4'b0100 : 4'b0000);
    end

    truth_table_scanner #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .abcd         (abcd),
        .f_dut        (f_dut),
        .f_ref        (f_ref),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .fail_seen    (fail_seen),
        .first_fail   (first_fail),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start is presented so that the next rising edge (edge 0) accepts it.
    task automatic kick(input logic ab);
        @(negedge clk);
        start = 1'b1;
        abort = ab;
        @(posedge clk);
    endtask

    // Observes cycles 1..max_cyc after edge 0; inputs set in cycle c are sampled at the end of cycle c.
    task automatic scan(input string name, input int st1, input int st2, input int ab_cyc,
                        input int max_cyc, output int done_cyc, output int done_n,
                        output int busy_fall, output int busy_hi);
        done_cyc  = -1;
        done_n    = 0;
        busy_fall = -1;
        busy_hi   = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy) busy_hi++;
            else if (busy_hi > 0 && busy_fall < 0) busy_fall = cyc;
            start = (cyc == st1) || (cyc == st2);
            abort = (cyc == ab_cyc);
        end
        start = 1'b0;
        abort = 1'b0;
        $display("scan %s: done_cyc=%0d done_n=%0d busy_fall=%0d mismatch_cnt=%0d fail_seen=%0d first_fail=%0d",
                 name, done_cyc, done_n, busy_fall, mismatch_cnt, fail_seen, first_fail);
    endtask

    function automatic logic [63:0] inv_tbl(input int upto);
        logic [63:0] r;
        logic [3:0]  v;
        r = '0;
        for (int k = 0; k < upto; k++) begin
            v = 4'(k);
            r[k*4 +: 4] = ~v;
        end
        return r;
    endfunction

    task automatic check_table(input string tag, input logic [63:0] exp_tbl);
        for (int k = 0; k < 16; k++) begin
            rd_addr = 4'(k);
            #1;
            chk($sformatf("%s[%0d]", tag, k), rd_data, exp_tbl[k*4 +: 4]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        rd_addr    = '0;
        fault_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_abcd", abcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mcnt", mismatch_cnt, 0);
        rst = 1'b0;

        scan("idle", -1, -1, -1, 20, dc, dn, bf, bh);
        chk("idle_done_n", dn, 0);
        chk("idle_busy", bh, 0);
        chk("idle_abcd", abcd, 0);
        chk("idle_fail", fail_seen, 0);
        chk("idle_first", first_fail, 0);
        check_table("idle_tbl", inv_tbl(0));

        kick(1'b0);
        scan("full", -1, -1, -1, 90, dc, dn, bf, bh);
        chk("full_done_cyc", dc, 81);
        chk("full_done_n", dn, 1);
        chk("full_busy_fall", bf, 82);
        chk("full_mcnt", mismatch_cnt, 0);
        chk("full_fail", fail_seen, 0);
        chk("full_abcd", abcd, 0);
        check_table("full_tbl", inv_tbl(16));

        fault_mask = 16'h1020;
        kick(1'b0);
        scan("faults", -1, -1, -1, 90, dc, dn, bf, bh);
        chk("flt_done_cyc", dc, 81);
        chk("flt_mcnt", mismatch_cnt, 2);
        chk("flt_fail", fail_seen, 1);
        chk("flt_first", first_fail, 5);

        fault_mask = 16'h0000;
        kick(1'b0);
        scan("start_busy", 10, 40, -1, 90, dc, dn, bf, bh);
        chk("sb_done_cyc", dc, 81);
        chk("sb_done_n", dn, 1);
        chk("sb_mcnt", mismatch_cnt, 0);
        chk("sb_fail", fail_seen, 0);

        kick(1'b1);
        scan("start_abort", -1, -1, -1, 10, dc, dn, bf, bh);
        chk("sa_busy", bh, 0);
        chk("sa_done_n", dn, 0);

        fault_mask = 16'h0024;
        kick(1'b0);
        scan("reset_mid", -1, -1, -1, 36, dc, dn, bf, bh);
        @(negedge clk);
        chk("rm_abcd_pre", abcd, 7);
        chk("rm_busy_pre", busy, 1);
        chk("rm_mcnt_pre", mismatch_cnt, 2);
        rst = 1'b1;
        #1;
        chk("rm_abcd", abcd, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_mcnt", mismatch_cnt, 0);
        chk("rm_fail", fail_seen, 0);
        chk("rm_first", first_fail, 0);
        #1 rst = 1'b0;
        check_table("rm_tbl", inv_tbl(0));

        kick(1'b0);
        scan("abort", -1, -1, 30, 40, dc, dn, bf, bh);
        chk("ab_done_n", dn, 0);
        chk("ab_busy_fall", bf, 31);
        chk("ab_abcd", abcd, 0);
        chk("ab_mcnt", mismatch_cnt, 1);
        chk("ab_fail", fail_seen, 1);
        chk("ab_first", first_fail, 2);
        check_table("ab_tbl", inv_tbl(5));

        kick(1'b0);
        scan("rescan", -1, -1, -1, 90, dc, dn, bf, bh);
        chk("rs_done_cyc", dc, 81);
        chk("rs_done_n", dn, 1);
        chk("rs_mcnt", mismatch_cnt, 2);
        chk("rs_first", first_fail, 2);
        check_table("rs_tbl", inv_tbl(16));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
